// File: rtl/v_result_writeback.sv
// Vector lane result writeback: captures ALU/MUL result groups on done-flag
// rising edges and drains them one word per cycle into the VRF write port.
module v_result_writeback #(
  parameter int DATA_W = 128,
  parameter int NWORDS = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              done_valu,
  input  logic              done_vmul,
  input  logic [DATA_W-1:0] result_valu_1,
  input  logic [DATA_W-1:0] result_valu_2,
  input  logic [DATA_W-1:0] result_valu_3,
  input  logic [DATA_W-1:0] result_valu_4,
  input  logic [DATA_W-1:0] result_vmul_1,
  input  logic [DATA_W-1:0] result_vmul_2,
  input  logic [DATA_W-1:0] result_vmul_3,
  input  logic [DATA_W-1:0] result_vmul_4,
  input  logic [ADDR_W-1:0] vd_alu,
  input  logic [ADDR_W-1:0] vd_mul,
  input  logic [2:0]        lmul,
  input  logic              vrf_wready,
  output logic              vrf_we,
  output logic [ADDR_W-1:0] vrf_waddr,
  output logic [DATA_W-1:0] vrf_wdata,
  output logic              wb_done,
  output logic              wb_src,
  output logic              busy,
  output logic              err_ovf
);

  localparam int KW = $clog2(NWORDS);
  localparam int CW = KW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ALU = 2'd1,
    WR_MUL = 2'd2
  } state_t;

  function automatic logic [CW-1:0] decode_cnt(input logic [2:0] l);
    logic [CW-1:0] c;
    case (l)
      3'b000:  c = CW'(1);
      3'b001:  c = CW'(2);
      3'b010:  c = CW'(4);
      default: c = CW'(1);
    endcase
    return c;
  endfunction

  state_t                        state_q, state_d;
  logic [KW-1:0]                 k_q, k_d;
  logic                          done_valu_q, done_vmul_q;
  logic                          pend_alu_q, pend_alu_d;
  logic                          pend_mul_q, pend_mul_d;
  logic [NWORDS-1:0][DATA_W-1:0] alu_buf_q, mul_buf_q;
  logic [ADDR_W-1:0]             alu_vd_q, mul_vd_q;
  logic [CW-1:0]                 alu_cnt_q, mul_cnt_q;
  logic                          wb_done_q, wb_src_q, err_ovf_q;

  logic              alu_ev_s, mul_ev_s, alu_cap_s, mul_cap_s;
  logic              we_s, accept_s, last_s, alu_last_s, mul_last_s;
  logic [CW-1:0]     cur_cnt_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;

  // Capture, acceptance and last-word decode
  always_comb begin
    alu_ev_s   = done_valu & ~done_valu_q;
    mul_ev_s   = done_vmul & ~done_vmul_q;
    we_s       = (state_q != IDLE);
    accept_s   = we_s & vrf_wready;
    cur_cnt_s  = (state_q == WR_MUL) ? mul_cnt_q : alu_cnt_q;
    last_s     = accept_s & (CW'(k_q) == (cur_cnt_s - CW'(1)));
    alu_last_s = last_s & (state_q == WR_ALU);
    mul_last_s = last_s & (state_q == WR_MUL);
    // A new result may land in the same edge that retires the buffer's last word
    alu_cap_s  = alu_ev_s & (~pend_alu_q | alu_last_s);
    mul_cap_s  = mul_ev_s & (~pend_mul_q | mul_last_s);
    if (alu_cap_s) begin
      pend_alu_d = 1'b1;
    end else if (alu_last_s) begin
      pend_alu_d = 1'b0;
    end else begin
      pend_alu_d = pend_alu_q;
    end
    if (mul_cap_s) begin
      pend_mul_d = 1'b1;
    end else if (mul_last_s) begin
      pend_mul_d = 1'b0;
    end else begin
      pend_mul_d = pend_mul_q;
    end
  end

  // Drain sequencer next state
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        k_d = KW'(0);
        if (pend_alu_q) begin
          state_d = WR_ALU;
        end else if (pend_mul_q) begin
          state_d = WR_MUL;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ALU: begin
        if (last_s) begin
          k_d     = KW'(0);
          state_d = pend_mul_q ? WR_MUL : IDLE;
        end else if (accept_s) begin
          k_d = k_q + KW'(1);
        end else begin
          k_d = k_q;
        end
      end
      WR_MUL: begin
        if (last_s) begin
          k_d     = KW'(0);
          state_d = pend_alu_q ? WR_ALU : IDLE;
        end else if (accept_s) begin
          k_d = k_q + KW'(1);
        end else begin
          k_d = k_q;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = KW'(0);
      end
    endcase
  end

  // Write port drive, zeroed when idle
  always_comb begin
    waddr_s = '0;
    wdata_s = '0;
    if (state_q == WR_ALU) begin
      waddr_s = alu_vd_q + ADDR_W'(k_q);
      wdata_s = alu_buf_q[k_q];
    end else if (state_q == WR_MUL) begin
      waddr_s = mul_vd_q + ADDR_W'(k_q);
      wdata_s = mul_buf_q[k_q];
    end else begin
      waddr_s = '0;
      wdata_s = '0;
    end
  end

  // State, buffers and status registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      done_valu_q <= 1'b0;
      done_vmul_q <= 1'b0;
      pend_alu_q  <= 1'b0;
      pend_mul_q  <= 1'b0;
      alu_buf_q   <= '0;
      mul_buf_q   <= '0;
      alu_vd_q    <= '0;
      mul_vd_q    <= '0;
      alu_cnt_q   <= '0;
      mul_cnt_q   <= '0;
      wb_done_q   <= 1'b0;
      wb_src_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      done_valu_q <= done_valu;
      done_vmul_q <= done_vmul;
      pend_alu_q  <= pend_alu_d;
      pend_mul_q  <= pend_mul_d;
      if (alu_cap_s) begin
        alu_buf_q <= {result_valu_4, result_valu_3, result_valu_2, result_valu_1};
        alu_vd_q  <= vd_alu;
        alu_cnt_q <= decode_cnt(lmul);
      end
      if (mul_cap_s) begin
        mul_buf_q <= {result_vmul_4, result_vmul_3, result_vmul_2, result_vmul_1};
        mul_vd_q  <= vd_mul;
        mul_cnt_q <= decode_cnt(lmul);
      end
      wb_done_q <= last_s;
      wb_src_q  <= mul_last_s;
      if ((alu_ev_s & ~alu_cap_s) | (mul_ev_s & ~mul_cap_s)) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

  assign vrf_we    = we_s;
  assign vrf_waddr = waddr_s;
  assign vrf_wdata = wdata_s;
  assign wb_done   = wb_done_q;
  assign wb_src    = wb_src_q;
  assign busy      = pend_alu_q | pend_mul_q | (state_q != IDLE);
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_v_result_writeback.sv
// Scoreboard bench for v_result_writeback: directed ops push expected writes
// and completions; a negedge monitor pops and compares.
module tb_v_result_writeback;
  localparam int DW = 128;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          nrst;
  logic          done_valu, done_vmul;
  logic [DW-1:0] rv1, rv2, rv3, rv4, rm1, rm2, rm3, rm4;
  logic [AW-1:0] vd_alu, vd_mul;
  logic [2:0]    lmul;
  logic          vrf_wready;
  logic          vrf_we, wb_done, wb_src, busy, err_ovf;
  logic [AW-1:0] vrf_waddr;
  logic [DW-1:0] vrf_wdata;

  v_result_writeback dut (
    .clk(clk), .nrst(nrst), .done_valu(done_valu), .done_vmul(done_vmul),
    .result_valu_1(rv1), .result_valu_2(rv2), .result_valu_3(rv3), .result_valu_4(rv4),
    .result_vmul_1(rm1), .result_vmul_2(rm2), .result_vmul_3(rm3), .result_vmul_4(rm4),
    .vd_alu(vd_alu), .vd_mul(vd_mul), .lmul(lmul), .vrf_wready(vrf_wready),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
    .wb_done(wb_done), .wb_src(wb_src), .busy(busy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t  exp_wr[$];
  logic exp_src[$];
  int   wr_cyc[$];
  int   done_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  e;
  logic es;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_src.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending writes expected 0", name, exp_wr.size());
    end
  endtask

  // Monitor: compares every accepted write and completion against the scoreboard
  always @(negedge clk) begin
    if (nrst) begin
      if (vrf_we && vrf_wready) begin
        wr_cyc.push_back(cyc);
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d expected none", vrf_waddr);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", DW'(vrf_waddr), DW'(e.a));
          chk("wr_data", vrf_wdata, e.d);
        end
      end
      if (!vrf_we) begin
        chk("idle_addr_data", DW'(vrf_waddr) | vrf_wdata, '0);
      end
      if (wb_done) begin
        done_cyc.push_back(cyc);
        if (exp_src.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb_done: got src %0d expected none", wb_src);
        end else begin
          es = exp_src.pop_front();
          chk("wb_src", DW'(wb_src), DW'(es));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; done_valu = 1'b0; done_vmul = 1'b0;
    rv1 = '0; rv2 = '0; rv3 = '0; rv4 = '0; rm1 = '0; rm2 = '0; rm3 = '0; rm4 = '0;
    vd_alu = '0; vd_mul = '0; lmul = 3'b000; vrf_wready = 1'b1;
    tick(); tick();
    chk("rst_we", DW'(vrf_we), '0);
    chk("rst_addr", DW'(vrf_waddr), '0);
    chk("rst_data", vrf_wdata, '0);
    chk("rst_done", DW'(wb_done), '0);
    chk("rst_src", DW'(wb_src), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_ovf", DW'(err_ovf), '0);
    nrst = 1'b1;
    tick();

    // Single ALU op, LMUL=1, with latency check
    vd_alu = 5'd5; lmul = 3'b000; rv1 = {16{8'hA5}};
    push_wr(5'd5, {16{8'hA5}}); exp_src.push_back(1'b0);
    wr_cyc.delete(); done_cyc.delete();
    done_valu = 1'b1;
    tick();
    chk("lat_idle_we", DW'(vrf_we), '0);
    chk("lat_busy", DW'(busy), DW'(1));
    tick();
    chk("lat_we", DW'(vrf_we), DW'(1));
    done_valu = 1'b0;
    wait_drain("alu1");
    chk("alu1_busy_after", DW'(busy), '0);
    chk("alu1_done_lat", DW'(done_cyc.size() == 1 && wr_cyc.size() == 1 && done_cyc[0] == wr_cyc[0] + 1), DW'(1));

    // MUL LMUL=4 with address wrap 30,31,0,1
    vd_mul = 5'd30; lmul = 3'b010;
    rm1 = DW'(1); rm2 = DW'(2); rm3 = DW'(3); rm4 = DW'(4);
    push_wr(5'd30, DW'(1)); push_wr(5'd31, DW'(2)); push_wr(5'd0, DW'(3)); push_wr(5'd1, DW'(4));
    exp_src.push_back(1'b1);
    wr_cyc.delete(); done_cyc.delete();
    done_vmul = 1'b1;
    tick();
    done_vmul = 1'b0;
    wait_drain("mul4");
    chk("mul4_nwr", DW'(wr_cyc.size()), DW'(4));
    chk("mul4_consec", DW'(wr_cyc.size() == 4 && wr_cyc[3] == wr_cyc[0] + 3), DW'(1));
    chk("mul4_ndone", DW'(done_cyc.size()), DW'(1));
    chk("mul4_done_lat", DW'(done_cyc.size() == 1 && wr_cyc.size() == 4 && done_cyc[0] == wr_cyc[3] + 1), DW'(1));

    // Simultaneous done: ALU then MUL with no bubble (shared lmul=2)
    vd_alu = 5'd2; vd_mul = 5'd8; lmul = 3'b001;
    rv1 = {4{32'hA1A1_0001}}; rv2 = {4{32'hA2A2_0002}};
    rm1 = {4{32'hB1B1_0011}}; rm2 = {4{32'hB2B2_0012}};
    push_wr(5'd2, {4{32'hA1A1_0001}}); push_wr(5'd3, {4{32'hA2A2_0002}});
    push_wr(5'd8, {4{32'hB1B1_0011}}); push_wr(5'd9, {4{32'hB2B2_0012}});
    exp_src.push_back(1'b0); exp_src.push_back(1'b1);
    wr_cyc.delete(); done_cyc.delete();
    done_valu = 1'b1; done_vmul = 1'b1;
    tick();
    done_valu = 1'b0; done_vmul = 1'b0;
    wait_drain("simul");
    chk("simul_no_bubble", DW'(wr_cyc.size() == 4 && wr_cyc[3] == wr_cyc[0] + 3), DW'(1));
    chk("simul_ndone", DW'(done_cyc.size()), DW'(2));

    // Backpressure: wready 1,0,0,1 over an LMUL=2 op
    vd_alu = 5'd10; lmul = 3'b001;
    rv1 = {8{16'hC0DE}}; rv2 = {8{16'hBEEF}};
    push_wr(5'd10, {8{16'hC0DE}}); push_wr(5'd11, {8{16'hBEEF}});
    exp_src.push_back(1'b0);
    wr_cyc.delete(); done_cyc.delete();
    done_valu = 1'b1;
    tick();
    done_valu = 1'b0;
    tick();
    tick();
    vrf_wready = 1'b0;
    chk("bp_hold1_addr", DW'(vrf_waddr), DW'(11));
    chk("bp_hold1_data", vrf_wdata, {8{16'hBEEF}});
    tick();
    chk("bp_hold2_we", DW'(vrf_we), DW'(1));
    chk("bp_hold2_addr", DW'(vrf_waddr), DW'(11));
    chk("bp_hold2_data", vrf_wdata, {8{16'hBEEF}});
    tick();
    vrf_wready = 1'b1;
    wait_drain("bp");
    chk("bp_naccept", DW'(wr_cyc.size()), DW'(2));

    // Recapture on the edge that accepts the last word: no overflow
    vd_alu = 5'd1; lmul = 3'b000; rv1 = {2{64'hD1D1_D1D1_0000_0001}};
    push_wr(5'd1, {2{64'hD1D1_D1D1_0000_0001}}); push_wr(5'd3, {2{64'hD2D2_D2D2_0000_0002}});
    exp_src.push_back(1'b0); exp_src.push_back(1'b0);
    done_valu = 1'b1;
    tick();
    done_valu = 1'b0;
    tick();
    done_valu = 1'b1; vd_alu = 5'd3; rv1 = {2{64'hD2D2_D2D2_0000_0002}};
    tick();
    done_valu = 1'b0;
    wait_drain("recap");
    chk("recap_no_ovf", DW'(err_ovf), '0);

    // Overflow: second ALU result while first is stalled
    vrf_wready = 1'b0;
    vd_alu = 5'd12; lmul = 3'b010;
    rv1 = DW'(32'hB1); rv2 = DW'(32'hB2); rv3 = DW'(32'hB3); rv4 = DW'(32'hB4);
    push_wr(5'd12, DW'(32'hB1)); push_wr(5'd13, DW'(32'hB2));
    push_wr(5'd14, DW'(32'hB3)); push_wr(5'd15, DW'(32'hB4));
    exp_src.push_back(1'b0);
    done_valu = 1'b1;
    tick();
    done_valu = 1'b0;
    tick();
    tick();
    chk("ovf_pre", DW'(err_ovf), '0);
    rv1 = DW'(32'hC1); rv2 = DW'(32'hC2); rv3 = DW'(32'hC3); rv4 = DW'(32'hC4);
    vd_alu = 5'd20; done_valu = 1'b1;
    tick();
    done_valu = 1'b0;
    chk("ovf_set", DW'(err_ovf), DW'(1));
    vrf_wready = 1'b1;
    wait_drain("ovf");
    chk("ovf_sticky", DW'(err_ovf), DW'(1));

    // Reset after two of four MUL writes
    vd_mul = 5'd20; lmul = 3'b010;
    rm1 = DW'(32'hE1); rm2 = DW'(32'hE2); rm3 = DW'(32'hE3); rm4 = DW'(32'hE4);
    push_wr(5'd20, DW'(32'hE1)); push_wr(5'd21, DW'(32'hE2));
    wr_cyc.delete(); done_cyc.delete();
    done_vmul = 1'b1;
    tick();
    done_vmul = 1'b0;
    tick();
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk("mid_rst_we", DW'(vrf_we), '0);
    chk("mid_rst_busy", DW'(busy), '0);
    chk("mid_rst_ovf", DW'(err_ovf), '0);
    chk("mid_rst_done", DW'(wb_done), '0);
    tick();
    tick();
    nrst = 1'b1;
    repeat (6) tick();
    chk("mid_rst_nwr", DW'(wr_cyc.size()), DW'(2));
    chk("mid_rst_exp_left", DW'(exp_wr.size()), '0);
    chk("mid_rst_no_done", DW'(done_cyc.size()), '0);
    chk("mid_rst_busy_after", DW'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/v_result_writeback.md
Name: v_result_writeback

Overview:
- Consumer end of the vector lane result interface.
- Watches the ALU and MUL lane done flags and captures the 128-bit result words (up to 4 per unit) when a done flag rises.
- Drains the captured words one per cycle into the vector register file write port, at vd, vd+1, … according to LMUL.
- Sits between the lane array and the VRF; each unit gets its own capture buffer, so an ALU op and a MUL op can complete back-to-back.

Parameters:
- DATA_W, 128, width of one result word / VRF row
- NWORDS, 4, max result words per unit (LMUL=4 group)
- ADDR_W, 5, VRF register index width (32 registers)

Ports:
- clk  in  1  system clock, rising edge active
- nrst  in  1  asynchronous active-low reset
- done_valu  in  1  ALU lane result-complete flag (level; rising edge = new result)
- done_vmul  in  1  MUL lane result-complete flag (level; rising edge = new result)
- result_valu_1..4  in  DATA_W each  ALU result words 1..4
- result_vmul_1..4  in  DATA_W each  MUL result words 1..4
- vd_alu  in  ADDR_W  destination base register for ALU op
- vd_mul  in  ADDR_W  destination base register for MUL op
- lmul  in  3  group size: 3'b000→1 word, 3'b001→2, 3'b010→4, others→1
- vrf_wready  in  1  VRF accepts write this cycle
- vrf_we  out  1  write request
- vrf_waddr  out  ADDR_W  write register index
- vrf_wdata  out  DATA_W  write data
- wb_done  out  1  one-cycle pulse: last word of an op accepted
- wb_src  out  1  valid with wb_done: 0=ALU, 1=MUL
- busy  out  1  any capture buffer pending or draining
- err_ovf  out  1  sticky: result arrived while that unit's buffer still pending

Behaviour:
- Reset (async, nrst=0): all outputs 0, both buffers empty, FSM=IDLE, edge-detect registers 0. Reset mid-drain discards remaining words; no wb_done is issued.
- Edge detect: registered copies done_valu_q/done_vmul_q. A capture event occurs at a rising clk edge where done_x=1 and done_x_q=0.
- Capture, at the event edge:
  - Latch the 4 words, vd, and count = decode(lmul); set pend_x=1.
  - lmul is sampled at the capture edge only.
  - If pend_x is already 1: new data dropped, err_ovf set (cleared only by reset).
- FSM states: IDLE, WR_ALU, WR_MUL.
  - IDLE: if pend_alu → WR_ALU, else if pend_mul → WR_MUL; k=0. Both pending → ALU first.
  - WR_x: vrf_we=1, vrf_waddr=(vd_x+k) mod 32 (wraps 31→0), vrf_wdata=word[k] (word 1 for k=0).
  - Advance: on an edge with vrf_we & vrf_wready, k++.
  - Last word (k=count-1) accepted: clear pend_x, wb_done=1 and wb_src=x for the following cycle. Next state is WR_other if the other unit is pending, else IDLE. There is no idle bubble between units.
  - vrf_wready=0 holds addr/data/we stable.
- Latency: capture at edge E → vrf_we high in cycle after E+1 (IDLE decision cycle). With vrf_wready=1 throughout, an LMUL=4 op issues 4 consecutive writes, and wb_done pulses 1 cycle after the 4th write.
- Capture into a buffer that is not the one being drained is legal at any time.
  - A capture of unit x during WR_x is overflow; the current drain completes with the old data.
  - Exception: the capture edge coincides with acceptance of x's last word. In that case the new capture wins and pend_x stays 1.
- busy = pend_alu | pend_mul | (state≠IDLE).
- vrf_we=0 in IDLE; vrf_waddr/vrf_wdata are 0 when vrf_we=0.

Test Plan:
- Reset then single ALU op: vd_alu=5, lmul=3'b000, result_valu_1=0xA5…A5, done_valu 0→1, wready=1 → one write (addr 5, data 0xA5…A5), wb_done=1 with wb_src=0 next cycle, busy=0 after.
- MUL LMUL=4 with wrap: vd_mul=30, lmul=3'b010, words 0x1..0x4 → writes to 30,31,0,1 with data 1,2,3,4 on consecutive cycles; one wb_done, wb_src=1.
- Simultaneous done: both flags rise same edge, ALU lmul=3'b001 vd=2, MUL vd=8 → writes 2,3 (ALU) then 8 immediately next cycle; two wb_done pulses, src 0 then 1.
- Backpressure: LMUL=2 op with vrf_wready toggling 1,0,0,1 → first word accepted, addr/data held stable for 2 cycles, second accepted; exactly 2 accepted writes.
- Overflow: ALU LMUL=4 draining with wready=0, second done_valu rising edge → err_ovf=1 (sticky), drained data equals the first op's words.
- Reset mid-drain: assert nrst=0 after 2 of 4 writes → vrf_we=0 immediately, no wb_done, busy=0, err_ovf=0.
